// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: AXI read-burst constants, address-field
// slicing shared with the fill unit, and the miss-request FSM states.
package cc_pkg;

  localparam logic [3:0] CC_ARLEN        = 4'd7;
  localparam logic [2:0] CC_ARSIZE       = 3'b011;
  localparam logic [1:0] CC_ARBURST_WRAP = 2'b10;

  // Byte-address fields of a 64-byte line built from 8 x 64-bit beats
  localparam int CC_TAG_MSB   = 31;
  localparam int CC_TAG_LSB   = 15;
  localparam int CC_INDEX_MSB = 14;
  localparam int CC_INDEX_LSB = 6;
  localparam int CC_BEAT_MSB  = 5;
  localparam int CC_BEAT_LSB  = 3;

  typedef enum logic {
    IDLE,
    AR_REQ
  } cc_state_e;

endpackage

// File: rtl/cc_miss_req_unit.sv
// Miss request unit: turns a tag-compare miss into one WRAP AR burst plus a
// miss-address FIFO push, and tracks outstanding line fills.
module cc_miss_req_unit
  import cc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ID_W            = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            miss_req_i,
  input  logic [31:0]     miss_addr_i,
  output logic            miss_ready_o,
  output logic            mem_arvalid_o,
  input  logic            mem_arready_i,
  output logic [31:0]     mem_araddr_o,
  output logic [ID_W-1:0] mem_arid_o,
  output logic [3:0]      mem_arlen_o,
  output logic [2:0]      mem_arsize_o,
  output logic [1:0]      mem_arburst_o,
  input  logic            mem_rvalid_i,
  input  logic            mem_rready_i,
  input  logic            mem_rlast_i,
  input  logic            miss_addr_fifo_full_i,
  output logic            miss_addr_fifo_wren_o,
  output logic [31:0]     miss_addr_fifo_wdata_o,
  output logic [3:0]      outstanding_o,
  output logic            err_o
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  cc_state_e       state_reg;
  logic            arvalid_reg;
  logic [31:0]     araddr_reg;
  logic [ID_W-1:0] next_id_reg;
  logic            fifo_wren_reg;
  logic [31:0]     fifo_wdata_reg;
  logic [3:0]      outstanding_reg;
  logic [3:0]      outstanding_next;
  logic            err_reg;
  logic            err_next;

  logic accept;
  logic ar_hs;
  logic r_done;

  assign miss_ready_o = (state_reg == IDLE) && !miss_addr_fifo_full_i
                        && (outstanding_reg < MAX_OUT);
  assign accept = miss_req_i && miss_ready_o;
  assign ar_hs  = arvalid_reg && mem_arready_i;
  assign r_done = mem_rvalid_i && mem_rready_i && mem_rlast_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      arvalid_reg    <= 1'b0;
      araddr_reg     <= 32'd0;
      next_id_reg    <= '0;
      fifo_wren_reg  <= 1'b0;
      fifo_wdata_reg <= 32'd0;
    end else begin
      fifo_wren_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg      <= AR_REQ;
            arvalid_reg    <= 1'b1;
            // Critical word first: the WRAP burst starts at the missing beat
            araddr_reg     <= {miss_addr_i[31:CC_BEAT_LSB], 3'b000};
            fifo_wren_reg  <= 1'b1;
            fifo_wdata_reg <= miss_addr_i;
          end
        end
        AR_REQ: begin
          if (mem_arready_i) begin
            state_reg   <= IDLE;
            arvalid_reg <= 1'b0;
            next_id_reg <= next_id_reg + ID_W'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          arvalid_reg <= 1'b0;
        end
      endcase
    end
  end

  // A last beat with nothing outstanding is a protocol error and is not counted
  always_comb begin
    outstanding_next = outstanding_reg;
    err_next         = err_reg;
    if (r_done && (outstanding_reg == 4'd0)) begin
      err_next = 1'b1;
      if (ar_hs) begin
        outstanding_next = outstanding_reg + 4'd1;
      end
    end else if (ar_hs && !r_done) begin
      outstanding_next = outstanding_reg + 4'd1;
    end else if (!ar_hs && r_done) begin
      outstanding_next = outstanding_reg - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_reg <= 4'd0;
      err_reg         <= 1'b0;
    end else begin
      outstanding_reg <= outstanding_next;
      err_reg         <= err_next;
    end
  end

  assign mem_arvalid_o          = arvalid_reg;
  assign mem_araddr_o           = araddr_reg;
  assign mem_arid_o             = next_id_reg;
  assign mem_arlen_o            = CC_ARLEN;
  assign mem_arsize_o           = CC_ARSIZE;
  assign mem_arburst_o          = CC_ARBURST_WRAP;
  assign miss_addr_fifo_wren_o  = fifo_wren_reg;
  assign miss_addr_fifo_wdata_o = fifo_wdata_reg;
  assign outstanding_o          = outstanding_reg;
  assign err_o                  = err_reg;

endmodule

// File: tb/tb_cc_miss_req_unit.sv
// Directed bench for cc_miss_req_unit: miss issue, AR backpressure,
// outstanding limit, FIFO full, counter corner cases and async reset.
module tb_cc_miss_req_unit;

  logic        clk;
  logic        rst;
  logic        miss_req_i;
  logic [31:0] miss_addr_i;
  logic        miss_ready_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arid_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        mem_rlast_i;
  logic        miss_addr_fifo_full_i;
  logic        miss_addr_fifo_wren_o;
  logic [31:0] miss_addr_fifo_wdata_o;
  logic [3:0]  outstanding_o;
  logic        err_o;

  int tests;
  int fails;

  cc_miss_req_unit #(.MAX_OUTSTANDING(2), .ID_W(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_i             (miss_req_i),
    .miss_addr_i            (miss_addr_i),
    .miss_ready_o           (miss_ready_o),
    .mem_arvalid_o          (mem_arvalid_o),
    .mem_arready_i          (mem_arready_i),
    .mem_araddr_o           (mem_araddr_o),
    .mem_arid_o             (mem_arid_o),
    .mem_arlen_o            (mem_arlen_o),
    .mem_arsize_o           (mem_arsize_o),
    .mem_arburst_o          (mem_arburst_o),
    .mem_rvalid_i           (mem_rvalid_i),
    .mem_rready_i           (mem_rready_i),
    .mem_rlast_i            (mem_rlast_i),
    .miss_addr_fifo_full_i  (miss_addr_fifo_full_i),
    .miss_addr_fifo_wren_o  (miss_addr_fifo_wren_o),
    .miss_addr_fifo_wdata_o (miss_addr_fifo_wdata_o),
    .outstanding_o          (outstanding_o),
    .err_o                  (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rlast(input logic v);
    mem_rvalid_i = v;
    mem_rready_i = v;
    mem_rlast_i  = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    miss_req_i = 1'b0;
    miss_addr_i = 32'd0;
    mem_arready_i = 1'b0;
    set_rlast(1'b0);
    miss_addr_fifo_full_i = 1'b0;
    tick();
    tick();

    // Reset state and constant AR fields
    chk("rst_arvalid", 32'(mem_arvalid_o), 32'd0);
    chk("rst_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_araddr", mem_araddr_o, 32'd0);
    chk("rst_wdata", miss_addr_fifo_wdata_o, 32'd0);
    rst = 1'b0;
    tick();
    chk("arlen", 32'(mem_arlen_o), 32'd7);
    chk("arsize", 32'(mem_arsize_o), 32'd3);
    chk("arburst", 32'(mem_arburst_o), 32'd2);

    // Single miss
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0001_2368;
    #1;
    chk("t1_ready", 32'(miss_ready_o), 32'd1);
    tick();
    miss_req_i = 1'b0;
    chk("t1_wren", 32'(miss_addr_fifo_wren_o), 32'd1);
    chk("t1_wdata", miss_addr_fifo_wdata_o, 32'h0001_2368);
    chk("t1_arvalid", 32'(mem_arvalid_o), 32'd1);
    chk("t1_araddr", mem_araddr_o, 32'h0001_2368);
    chk("t1_arid", 32'(mem_arid_o), 32'd0);
    chk("t1_ready_busy", 32'(miss_ready_o), 32'd0);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t1_arvalid_done", 32'(mem_arvalid_o), 32'd0);
    chk("t1_wren_once", 32'(miss_addr_fifo_wren_o), 32'd0);
    chk("t1_outstanding", 32'(outstanding_o), 32'd1);
    set_rlast(1'b1);
    tick();
    set_rlast(1'b0);
    chk("t1_drain", 32'(outstanding_o), 32'd0);
    chk("t1_err", 32'(err_o), 32'd0);

    // AR backpressure: five stalled cycles then handshake
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_1004;
    tick();
    miss_req_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2_arvalid_%0d", i), 32'(mem_arvalid_o), 32'd1);
      chk($sformatf("t2_araddr_%0d", i), mem_araddr_o, 32'h0000_1000);
      chk($sformatf("t2_arid_%0d", i), 32'(mem_arid_o), 32'd1);
      chk($sformatf("t2_ready_%0d", i), 32'(miss_ready_o), 32'd0);
      tick();
    end
    chk("t2_wren_once", 32'(miss_addr_fifo_wren_o), 32'd0);
    chk("t2_outst_stall", 32'(outstanding_o), 32'd0);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t2_arvalid_done", 32'(mem_arvalid_o), 32'd0);
    chk("t2_outstanding", 32'(outstanding_o), 32'd1);
    set_rlast(1'b1);
    tick();
    set_rlast(1'b0);
    chk("t2_drain", 32'(outstanding_o), 32'd0);

    // Outstanding limit, fresh IDs from reset
    do_reset();
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_2000;
    tick();
    miss_req_i = 1'b0;
    chk("t3_arid_a", 32'(mem_arid_o), 32'd0);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_2040;
    tick();
    miss_req_i = 1'b0;
    chk("t3_arid_b", 32'(mem_arid_o), 32'd1);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t3_outstanding_2", 32'(outstanding_o), 32'd2);
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_2080;
    #1;
    chk("t3_ready_full", 32'(miss_ready_o), 32'd0);
    tick();
    chk("t3_no_arvalid", 32'(mem_arvalid_o), 32'd0);
    chk("t3_no_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
    set_rlast(1'b1);
    tick();
    set_rlast(1'b0);
    chk("t3_outstanding_1", 32'(outstanding_o), 32'd1);
    chk("t3_ready_again", 32'(miss_ready_o), 32'd1);
    tick();
    miss_req_i = 1'b0;
    chk("t3_arvalid_c", 32'(mem_arvalid_o), 32'd1);
    chk("t3_arid_c", 32'(mem_arid_o), 32'd2);
    chk("t3_wdata_c", miss_addr_fifo_wdata_o, 32'h0000_2080);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t3_outstanding_c", 32'(outstanding_o), 32'd2);
    set_rlast(1'b1);
    tick();
    tick();
    set_rlast(1'b0);
    chk("t3_drain", 32'(outstanding_o), 32'd0);

    // FIFO full blocks acceptance
    miss_addr_fifo_full_i = 1'b1;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_300D;
    #1;
    chk("t4_ready_full", 32'(miss_ready_o), 32'd0);
    tick();
    chk("t4_no_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
    chk("t4_no_arvalid", 32'(mem_arvalid_o), 32'd0);
    miss_addr_fifo_full_i = 1'b0;
    #1;
    chk("t4_ready", 32'(miss_ready_o), 32'd1);
    tick();
    miss_req_i = 1'b0;
    chk("t4_wren", 32'(miss_addr_fifo_wren_o), 32'd1);
    chk("t4_wdata", miss_addr_fifo_wdata_o, 32'h0000_300D);
    chk("t4_araddr", mem_araddr_o, 32'h0000_3008);
    chk("t4_arid", 32'(mem_arid_o), 32'd3);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t4_outstanding", 32'(outstanding_o), 32'd1);

    // Same-cycle AR handshake and RLAST, then spurious RLAST
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_4010;
    tick();
    miss_req_i = 1'b0;
    mem_arready_i = 1'b1;
    set_rlast(1'b1);
    tick();
    mem_arready_i = 1'b0;
    set_rlast(1'b0);
    chk("t5_same_cycle", 32'(outstanding_o), 32'd1);
    chk("t5_arvalid_done", 32'(mem_arvalid_o), 32'd0);
    set_rlast(1'b1);
    tick();
    chk("t5_drain", 32'(outstanding_o), 32'd0);
    chk("t5_err_clear", 32'(err_o), 32'd0);
    tick();
    set_rlast(1'b0);
    chk("t5_no_underflow", 32'(outstanding_o), 32'd0);
    chk("t5_err_set", 32'(err_o), 32'd1);
    tick();
    tick();
    chk("t5_err_sticky", 32'(err_o), 32'd1);

    // Async reset while in AR_REQ with a fill outstanding
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_5000;
    tick();
    miss_req_i = 1'b0;
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_5040;
    tick();
    miss_req_i = 1'b0;
    chk("t6_pre_arvalid", 32'(mem_arvalid_o), 32'd1);
    chk("t6_pre_outstanding", 32'(outstanding_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_arvalid", 32'(mem_arvalid_o), 32'd0);
    chk("t6_wren", 32'(miss_addr_fifo_wren_o), 32'd0);
    chk("t6_outstanding", 32'(outstanding_o), 32'd0);
    chk("t6_err", 32'(err_o), 32'd0);
    tick();
    rst = 1'b0;
    miss_req_i = 1'b1;
    miss_addr_i = 32'h0000_6018;
    #1;
    chk("t6_ready", 32'(miss_ready_o), 32'd1);
    tick();
    miss_req_i = 1'b0;
    chk("t6_new_arvalid", 32'(mem_arvalid_o), 32'd1);
    chk("t6_new_arid", 32'(mem_arid_o), 32'd0);
    chk("t6_new_araddr", mem_araddr_o, 32'h0000_6018);
    mem_arready_i = 1'b1;
    tick();
    mem_arready_i = 1'b0;
    chk("t6_new_outstanding", 32'(outstanding_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
